// File: rtl/gpu_fill_rect_pkg.sv
// Shared constants and types for the rectangle fill engine and its neighbours
// (the line engine reuses the pixel bus struct).
package gpu_fill_rect_pkg;

    localparam int GPU_WIDTH_BITS   = 10;
    localparam int GPU_HEIGHT_BITS  = 9;
    localparam int GPU_CHANNEL_BITS = 8;
    localparam int GPU_SCREEN_W     = 640;
    localparam int GPU_SCREEN_H     = 480;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_FILL  = 2'd2,
        ST_DONE  = 2'd3
    } fill_state_t;

    typedef struct packed {
        logic [GPU_WIDTH_BITS-1:0]   x;
        logic [GPU_HEIGHT_BITS-1:0]  y;
        logic [GPU_CHANNEL_BITS-1:0] r;
        logic [GPU_CHANNEL_BITS-1:0] g;
        logic [GPU_CHANNEL_BITS-1:0] b;
    } pixel_t;

endpackage

// File: rtl/gpu_fill_rect_bounds.sv
// Combinational corner ordering and screen clipping for the fill engine.
// empty flags a rectangle that starts entirely off-screen.
module gpu_fill_rect_bounds
    import gpu_fill_rect_pkg::*;
#(
    parameter int WIDTH_BITS  = GPU_WIDTH_BITS,
    parameter int HEIGHT_BITS = GPU_HEIGHT_BITS,
    parameter int SCREEN_W    = GPU_SCREEN_W,
    parameter int SCREEN_H    = GPU_SCREEN_H
) (
    input  logic [WIDTH_BITS-1:0]  x1,
    input  logic [HEIGHT_BITS-1:0] y1,
    input  logic [WIDTH_BITS-1:0]  x2,
    input  logic [HEIGHT_BITS-1:0] y2,
    output logic [WIDTH_BITS-1:0]  xmin,
    output logic [WIDTH_BITS-1:0]  xmax,
    output logic [HEIGHT_BITS-1:0] ymin,
    output logic [HEIGHT_BITS-1:0] ymax,
    output logic                   empty
);

    localparam logic [WIDTH_BITS-1:0]  X_LIM = WIDTH_BITS'(SCREEN_W - 1);
    localparam logic [HEIGHT_BITS-1:0] Y_LIM = HEIGHT_BITS'(SCREEN_H - 1);

    logic [WIDTH_BITS-1:0]  x_hi;
    logic [HEIGHT_BITS-1:0] y_hi;

    always_comb begin
        xmin  = (x1 < x2) ? x1 : x2;
        x_hi  = (x1 < x2) ? x2 : x1;
        ymin  = (y1 < y2) ? y1 : y2;
        y_hi  = (y1 < y2) ? y2 : y1;
        xmax  = (x_hi > X_LIM) ? X_LIM : x_hi;
        ymax  = (y_hi > Y_LIM) ? Y_LIM : y_hi;
        empty = (xmin > X_LIM) || (ymin > Y_LIM);
    end

endmodule

// File: rtl/gpu_fill_rect.sv
// Rectangle fill engine: latches a fill command, then emits one pixel write
// per valid/ready handshake in raster order, and pulses finished_o when done.
module gpu_fill_rect
    import gpu_fill_rect_pkg::*;
#(
    parameter int WIDTH_BITS   = GPU_WIDTH_BITS,
    parameter int HEIGHT_BITS  = GPU_HEIGHT_BITS,
    parameter int CHANNEL_BITS = GPU_CHANNEL_BITS,
    parameter int SCREEN_W     = GPU_SCREEN_W,
    parameter int SCREEN_H     = GPU_SCREEN_H
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    run_i,
    input  logic [WIDTH_BITS-1:0]   x1_i,
    input  logic [HEIGHT_BITS-1:0]  y1_i,
    input  logic [WIDTH_BITS-1:0]   x2_i,
    input  logic [HEIGHT_BITS-1:0]  y2_i,
    input  logic [CHANNEL_BITS-1:0] r_i,
    input  logic [CHANNEL_BITS-1:0] g_i,
    input  logic [CHANNEL_BITS-1:0] b_i,
    output logic [WIDTH_BITS-1:0]   px_x_o,
    output logic [HEIGHT_BITS-1:0]  px_y_o,
    output logic [CHANNEL_BITS-1:0] px_r_o,
    output logic [CHANNEL_BITS-1:0] px_g_o,
    output logic [CHANNEL_BITS-1:0] px_b_o,
    output logic                    px_valid_o,
    input  logic                    px_ready_i,
    output logic                    busy_o,
    output logic                    finished_o
);

    fill_state_t             state_reg;
    logic [WIDTH_BITS-1:0]   x1_reg, x2_reg, xmin_reg, xmax_reg, x_reg;
    logic [HEIGHT_BITS-1:0]  y1_reg, y2_reg, ymax_reg, y_reg;
    logic [CHANNEL_BITS-1:0] r_reg, g_reg, b_reg;
    logic                    px_valid_reg;
    logic                    finished_reg;

    logic [WIDTH_BITS-1:0]   bnd_xmin, bnd_xmax;
    logic [HEIGHT_BITS-1:0]  bnd_ymin, bnd_ymax;
    logic                    bnd_empty;

    gpu_fill_rect_bounds #(
        .WIDTH_BITS  (WIDTH_BITS),
        .HEIGHT_BITS (HEIGHT_BITS),
        .SCREEN_W    (SCREEN_W),
        .SCREEN_H    (SCREEN_H)
    ) u_bounds (
        .x1    (x1_reg),
        .y1    (y1_reg),
        .x2    (x2_reg),
        .y2    (y2_reg),
        .xmin  (bnd_xmin),
        .xmax  (bnd_xmax),
        .ymin  (bnd_ymin),
        .ymax  (bnd_ymax),
        .empty (bnd_empty)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg    <= ST_IDLE;
            x1_reg       <= '0;
            y1_reg       <= '0;
            x2_reg       <= '0;
            y2_reg       <= '0;
            r_reg        <= '0;
            g_reg        <= '0;
            b_reg        <= '0;
            xmin_reg     <= '0;
            xmax_reg     <= '0;
            ymax_reg     <= '0;
            x_reg        <= '0;
            y_reg        <= '0;
            px_valid_reg <= 1'b0;
            finished_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    finished_reg <= 1'b0;
                    if (run_i) begin
                        x1_reg    <= x1_i;
                        y1_reg    <= y1_i;
                        x2_reg    <= x2_i;
                        y2_reg    <= y2_i;
                        r_reg     <= r_i;
                        g_reg     <= g_i;
                        b_reg     <= b_i;
                        state_reg <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (bnd_empty) begin
                        finished_reg <= 1'b1;
                        state_reg    <= ST_DONE;
                    end else begin
                        xmin_reg     <= bnd_xmin;
                        xmax_reg     <= bnd_xmax;
                        ymax_reg     <= bnd_ymax;
                        x_reg        <= bnd_xmin;
                        y_reg        <= bnd_ymin;
                        px_valid_reg <= 1'b1;
                        state_reg    <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    // Counters only move on a handshake so a stalled pixel stays put.
                    if (px_valid_reg && px_ready_i) begin
                        if (x_reg < xmax_reg) begin
                            x_reg <= x_reg + WIDTH_BITS'(1);
                        end else if (y_reg < ymax_reg) begin
                            x_reg <= xmin_reg;
                            y_reg <= y_reg + HEIGHT_BITS'(1);
                        end else begin
                            px_valid_reg <= 1'b0;
                            finished_reg <= 1'b1;
                            state_reg    <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    finished_reg <= 1'b0;
                    state_reg    <= ST_IDLE;
                end
                default: begin
                    px_valid_reg <= 1'b0;
                    finished_reg <= 1'b0;
                    state_reg    <= ST_IDLE;
                end
            endcase
        end
    end

    assign px_x_o     = x_reg;
    assign px_y_o     = y_reg;
    assign px_r_o     = r_reg;
    assign px_g_o     = g_reg;
    assign px_b_o     = b_reg;
    assign px_valid_o = px_valid_reg;
    assign finished_o = finished_reg;
    assign busy_o     = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_gpu_fill_rect.sv
// Scoreboard bench for gpu_fill_rect: expected pixels are queued per command
// and popped on every observed handshake.
module tb_gpu_fill_rect;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       run_i;
    logic [9:0] x1_i, x2_i;
    logic [8:0] y1_i, y2_i;
    logic [7:0] r_i, g_i, b_i;
    logic [9:0] px_x_o;
    logic [8:0] px_y_o;
    logic [7:0] px_r_o, px_g_o, px_b_o;
    logic       px_valid_o;
    logic       px_ready_i;
    logic       busy_o;
    logic       finished_o;

    int          n_checks = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          ready_mode = 0;
    logic [63:0] exp_q[$];
    int          hs_count = 0, hs_last_cyc = -1;
    int          fin_count = 0, fin_last_cyc = -1;
    int          first_valid_cyc = -1;
    logic [63:0] last_px = '0, prev_px = '0;
    bit          stall_prev = 0;

    gpu_fill_rect dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .run_i      (run_i),
        .x1_i       (x1_i),
        .y1_i       (y1_i),
        .x2_i       (x2_i),
        .y2_i       (y2_i),
        .r_i        (r_i),
        .g_i        (g_i),
        .b_i        (b_i),
        .px_x_o     (px_x_o),
        .px_y_o     (px_y_o),
        .px_r_o     (px_r_o),
        .px_g_o     (px_g_o),
        .px_b_o     (px_b_o),
        .px_valid_o (px_valid_o),
        .px_ready_i (px_ready_i),
        .busy_o     (busy_o),
        .finished_o (finished_o)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pack_px(input int x, input int y, input int r, input int g, input int b);
        return {21'd0, x[9:0], y[8:0], r[7:0], g[7:0], b[7:0]};
    endfunction

    function automatic logic [63:0] cur_px();
        return {21'd0, px_x_o, px_y_o, px_r_o, px_g_o, px_b_o};
    endfunction

    // Reference raster: order corners, clip to 640x480, x fastest.
    task automatic push_expected(input int x1, input int y1, input int x2, input int y2,
                                 input int r, input int g, input int b, output int n);
        int xl, xh, yl, yh;
        xl = (x1 < x2) ? x1 : x2;
        xh = (x1 < x2) ? x2 : x1;
        yl = (y1 < y2) ? y1 : y2;
        yh = (y1 < y2) ? y2 : y1;
        if (xh > 639) xh = 639;
        if (yh > 479) yh = 479;
        n = 0;
        if (xl <= 639 && yl <= 479) begin
            for (int y = yl; y <= yh; y++) begin
                for (int x = xl; x <= xh; x++) begin
                    exp_q.push_back(pack_px(x, y, r, g, b));
                    n++;
                end
            end
        end
    endtask

    initial begin
        px_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 1) px_ready_i = ~px_ready_i;
            else px_ready_i = 1'b1;
        end
    end

    // Monitor: handshakes, stall stability, finished pulses.
    initial forever begin
        @(negedge clk);
        if (n_rst) begin
            if (stall_prev) begin
                chk("hold_valid", px_valid_o, 1);
                if (px_valid_o) chk("hold_px", cur_px(), prev_px);
            end
            if (px_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (px_valid_o && px_ready_i) begin
                hs_count++;
                hs_last_cyc = cyc;
                last_px = cur_px();
                chk("sb_nonempty", 64'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) chk("pixel", cur_px(), exp_q.pop_front());
            end
            if (finished_o) begin
                fin_count++;
                fin_last_cyc = cyc;
                chk("fin_no_valid", px_valid_o, 0);
            end
            stall_prev = px_valid_o && !px_ready_i;
            prev_px = cur_px();
        end else begin
            stall_prev = 0;
        end
    end

    task automatic clear_stats();
        hs_count = 0;
        hs_last_cyc = -1;
        fin_count = 0;
        fin_last_cyc = -1;
        first_valid_cyc = -1;
    endtask

    task automatic start_cmd(input int x1, input int y1, input int x2, input int y2,
                             input int r, input int g, input int b, output int start);
        @(posedge clk);
        #1;
        start = cyc;
        x1_i = x1[9:0];
        y1_i = y1[8:0];
        x2_i = x2[9:0];
        y2_i = y2[8:0];
        r_i = r[7:0];
        g_i = g[7:0];
        b_i = b[7:0];
        run_i = 1'b1;
        @(posedge clk);
        #1;
        run_i = 1'b0;
        x1_i = 10'($urandom);
        y1_i = 9'($urandom);
        x2_i = 10'($urandom);
        y2_i = 9'($urandom);
        r_i = 8'($urandom);
        g_i = 8'($urandom);
        b_i = 8'($urandom);
    endtask

    // rerun: 0 none, 1 pulse run_i during FILL, 2 pulse run_i during DONE.
    task automatic do_fill(input int x1, input int y1, input int x2, input int y2,
                           input int r, input int g, input int b,
                           input int rerun, input string name);
        int n, start, idle_at;
        bit done, seen_busy, rerun_used;
        push_expected(x1, y1, x2, y2, r, g, b, n);
        clear_stats();
        start_cmd(x1, y1, x2, y2, r, g, b, start);
        done = 0;
        seen_busy = 0;
        rerun_used = 0;
        idle_at = 0;
        for (int k = 0; k < 3000 && !done; k++) begin
            @(negedge clk);
            #2;
            if (run_i) begin
                run_i = 1'b0;
            end else if (!rerun_used) begin
                if (rerun == 1 && px_valid_o && hs_count >= 2) begin
                    x1_i = 10'd0; y1_i = 9'd0; x2_i = 10'd1; y2_i = 9'd1;
                    run_i = 1'b1;
                    rerun_used = 1;
                end else if (rerun == 2 && finished_o) begin
                    x1_i = 10'd7; y1_i = 9'd7; x2_i = 10'd8; y2_i = 9'd8;
                    run_i = 1'b1;
                    rerun_used = 1;
                end
            end
            if (busy_o) seen_busy = 1;
            else if (seen_busy) begin
                done = 1;
                idle_at = cyc;
            end
        end
        run_i = 1'b0;
        if (rerun != 0) chk({name, "_rerun_driven"}, 64'(rerun_used), 1);
        chk({name, "_timeout"}, 64'(done), 1);
        chk({name, "_handshakes"}, hs_count, n);
        chk({name, "_fin_count"}, fin_count, 1);
        if (n > 0) begin
            chk({name, "_first_valid"}, first_valid_cyc - start, 2);
            chk({name, "_fin_latency"}, fin_last_cyc - hs_last_cyc, 1);
        end else begin
            chk({name, "_fin_at"}, fin_last_cyc - start, 2);
            chk({name, "_no_valid"}, 64'(first_valid_cyc < 0), 1);
        end
        if (ready_mode == 0) chk({name, "_run_to_idle"}, idle_at - start, n + 3);
        chk({name, "_sb_left"}, exp_q.size(), 0);
        exp_q.delete();
        $display("cmd %s (%0d,%0d)-(%0d,%0d) expect=%0d handshakes=%0d cycles=%0d",
                 name, x1, y1, x2, y2, n, hs_count, idle_at - start);
    endtask

    initial begin
        int n, start;
        bit hit;
        n_rst = 1'b0;
        run_i = 1'b0;
        x1_i = '0; y1_i = '0; x2_i = '0; y2_i = '0;
        r_i = '0; g_i = '0; b_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_valid", px_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_fin", finished_o, 0);
        chk("rst_px", cur_px(), 0);
        n_rst = 1'b1;

        do_fill(2, 3, 4, 4, 10, 9, 8, 0, "basic");
        do_fill(4, 4, 2, 3, 10, 9, 8, 0, "swapped");
        ready_mode = 1;
        do_fill(2, 3, 4, 4, 10, 9, 8, 0, "stall");
        ready_mode = 0;
        do_fill(630, 470, 700, 500, 1, 2, 3, 0, "clip");
        chk("clip_last", last_px, pack_px(639, 479, 1, 2, 3));
        do_fill(650, 10, 700, 20, 4, 5, 6, 0, "offscreen");

        // Abort a fill with reset after three accepted pixels.
        push_expected(0, 0, 9, 9, 33, 44, 55, n);
        clear_stats();
        start_cmd(0, 0, 9, 9, 33, 44, 55, start);
        hit = 0;
        for (int k = 0; k < 200 && !hit; k++) begin
            @(negedge clk);
            #2;
            if (hs_count >= 3) hit = 1;
        end
        chk("rst_wait_timeout", 64'(hit), 1);
        @(posedge clk);
        #1;
        n_rst = 1'b0;
        #1;
        chk("abort_valid", px_valid_o, 0);
        chk("abort_busy", busy_o, 0);
        repeat (3) @(negedge clk);
        chk("abort_fin", fin_count, 0);
        chk("abort_hs", hs_count, 3);
        chk("abort_left", exp_q.size(), n - 3);
        exp_q.delete();
        $display("cmd abort (0,0)-(9,9) handshakes=%0d before reset", hs_count);
        n_rst = 1'b1;
        do_fill(5, 5, 5, 5, 77, 88, 99, 0, "point");

        do_fill(2, 3, 4, 4, 10, 9, 8, 1, "rerun_fill");
        do_fill(2, 3, 4, 4, 10, 9, 8, 2, "rerun_done");
        repeat (3) @(negedge clk);
        chk("post_idle_busy", busy_o, 0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/gpu_fill_rect.md
Name: gpu_fill_rect

Overview:
Rectangle fill engine directly downstream of gpu_controller. It consumes the controller's fill command bus (x1/y1/x2/y2/r/g/b with run_fill) and rasterises the axis-aligned filled rectangle into one pixel write per handshake toward the framebuffer write arbiter. It returns finished_fill to the controller on completion. Colour is constant for the whole command.

Parameters:
WIDTH_BITS, 10, x coordinate width (equals `WIDTH_BITS in gpu_definitions.vh)
HEIGHT_BITS, 9, y coordinate width (equals `HEIGHT_BITS)
CHANNEL_BITS, 8, per-channel colour width (equals `CHANNEL_BITS)
SCREEN_W, 640, visible width in pixels; x clip limit is SCREEN_W-1
SCREEN_H, 480, visible height in pixels; y clip limit is SCREEN_H-1

Ports:
clk  in  1  system clock, rising edge
n_rst  in  1  asynchronous active-low reset
run_i  in  1  start pulse from controller (run_fill_o)
x1_i  in  WIDTH_BITS  corner A x
y1_i  in  HEIGHT_BITS  corner A y
x2_i  in  WIDTH_BITS  corner B x
y2_i  in  HEIGHT_BITS  corner B y
r_i, g_i, b_i  in  CHANNEL_BITS each  fill colour
px_x_o  out  WIDTH_BITS  pixel x
px_y_o  out  HEIGHT_BITS  pixel y
px_r_o, px_g_o, px_b_o  out  CHANNEL_BITS each  pixel colour
px_valid_o  out  1  pixel write request
px_ready_i  in  1  downstream accepts pixel
busy_o  out  1  high in any state other than IDLE
finished_o  out  1  one-cycle done pulse (finished_fill_i of controller)

Behaviour:
- Reset (async, n_rst=0): state IDLE; all outputs 0; px_valid_o drops immediately, not at the next edge. Reset mid-fill abandons the command with no finished_o pulse.
- States: IDLE, SETUP, FILL, DONE.
- IDLE: on run_i=1, latch all operands and the colour; go to SETUP. run_i in any other state is ignored and is not queued.
- SETUP (one cycle):
  - xmin=min(x1,x2), xmax=max(x1,x2), ymin=min(y1,y2), ymax=max(y1,y2).
  - Clip xmax to SCREEN_W-1 and ymax to SCREEN_H-1.
  - If xmin>SCREEN_W-1 or ymin>SCREEN_H-1, go to DONE with no pixels emitted. Otherwise load x=xmin, y=ymin and go to FILL.
- FILL:
  - px_valid_o=1 and px_x_o/px_y_o = current counters; colour outputs hold the latched colour.
  - Outputs must stay stable while px_valid_o=1 and px_ready_i=0.
  - On a handshake (valid & ready):
    - if x<xmax: x++
    - else if y<ymax: x=xmin, y++
    - else (last pixel): go to DONE.
  - Order is raster, x fastest.
- DONE: finished_o=1 and px_valid_o=0 for exactly one cycle, then IDLE. A run_i in this cycle is ignored.
- Latency and throughput:
  - run_i at edge 0 gives first px_valid_o after edge 2.
  - With px_ready_i held high, one pixel per cycle.
  - finished_o is asserted in the cycle after the last handshake.
  - Total for N pixels with ready=1: N+3 cycles run-to-IDLE.
- Widths: comparisons are unsigned. Counters do not wrap, because the xmax/ymax clip bounds are less than 2^WIDTH_BITS and 2^HEIGHT_BITS.
- Degenerate cases: x1=x2 or y1=y2 produce a single line of pixels; a single point produces one pixel.
- Outputs in IDLE: px_* hold their last values; only px_valid_o is guaranteed 0.

Decomposition:
- Shared package/header gpu_definitions.vh holds:
  - WIDTH_BITS, HEIGHT_BITS, CHANNEL_BITS, SCREEN_W, SCREEN_H constants
  - fill-state enum typedef (IDLE/SETUP/FILL/DONE)
  - pixel-bus struct typedef {x, y, r, g, b}, reused by the line engine.
- One natural sub-module: gpu_rect_bounds, a combinational min/max/clip unit producing xmin/xmax/ymin/ymax/empty. Everything else is the top-level FSM and counters.

Test Plan:
1. run_i with (2,3)-(4,4), colour (10,9,8), ready=1 -> 6 pixels in order (2,3),(3,3),(4,3),(2,4),(3,4),(4,4), all coloured (10,9,8); finished_o one cycle after the last, busy for 9 cycles.
2. Swapped corners (4,4)-(2,3) -> sequence identical to scenario 1.
3. Scenario 1 with px_ready_i toggling 1,0,1,0… -> outputs stable during ready=0; exactly 6 handshakes; no duplicate or skipped pixel.
4. Clipping:
   - (630,470)-(700,500) -> 100 pixels, x 630..639, y 470..479, last pixel (639,479).
   - (650,10)-(700,20) -> zero px_valid_o; finished_o in the third cycle after run_i.
5. n_rst pulsed low after 3 handshakes of (0,0)-(9,9) -> px_valid_o=0 asynchronously, no finished_o. Then a new run (5,5)-(5,5) -> exactly one pixel (5,5) and finished_o.
6. run_i re-asserted during FILL and during DONE -> ignored; only the original command's pixels and a single finished_o pulse appear.
